// File: rtl/pcm_capture_ctrl.sv
// pcm_capture_ctrl: capture sequencer for a decimated PCM stream.
// A one-cycle start request runs a capture sequence: the decimator is
// enabled, the first SETTLE_SAMPLES decimated samples are discarded, and the
// following samples are written into a FIFO capture buffer. The sequence
// ends after sample_count samples (0 = run until stop) or on stop. The
// buffer is readable at all times; rd_data/rd_valid arrive one cycle after
// rd_en.
//
// Optional build macro PCM_CAPTURE_OVERFLOW_STOP_EN: when defined, the first
// sample dropped because the buffer is full also ends the capture. When it
// is undefined, dropped samples are only counted and flagged, and the
// capture keeps running.
//
// Handshakes: ds_valid is a single-cycle strobe with no backpressure.
// rd_en is a request. It is honoured only when level != 0, and each honoured
// request produces exactly one rd_valid pulse in the following cycle.
module pcm_capture_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int SETTLE_SAMPLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic [15:0]                   sample_count,
  output logic                          ds_enable,
  input  logic                          ds_valid,
  input  logic [DATA_WIDTH-1:0]         ds_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [1:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam bit SKIP_SETTLE = (SETTLE_SAMPLES == 0);
  localparam logic [15:0] SETTLE_LAST =
    16'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [15:0]           count_q;
  logic [15:0]           cap_cnt;
  logic [15:0]           settle_cnt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  logic full;
  logic empty;
  logic pop;
  logic push_req;
  logic push;
  logic drop;
  logic cap_last;
  logic settle_last;
  logic accept_start;

  // Buffer and capture qualifiers. A push into a full buffer is allowed
  // when a pop frees the head entry in the same cycle.
  always_comb begin
    full         = (level == LEVEL_FULL);
    empty        = (level == '0);
    pop          = rd_en && !empty;
    push_req     = (state == CAPTURE) && ds_valid;
    push         = push_req && (!full || pop);
    drop         = push_req && full && !pop;
    cap_last     = (count_q != 16'd0) && ((cap_cnt + 16'd1) == count_q);
    settle_last  = (settle_cnt == SETTLE_LAST);
    accept_start = (state == IDLE) && start;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    next_state = state;
    ds_enable  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SKIP_SETTLE ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        ds_enable = 1'b1;
        busy      = 1'b1;
        if (stop) begin
          next_state = DONE;
        end else if (ds_valid && settle_last) begin
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        ds_enable = 1'b1;
        busy      = 1'b1;
        if (stop || (push_req && cap_last)) begin
          next_state = DONE;
        end
`ifdef PCM_CAPTURE_OVERFLOW_STOP_EN
        if (drop) begin
          next_state = DONE;
        end
`endif
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign state_dbg = state;

  // Latched request and the settle/capture strobe counters. The capture
  // counter advances on every capture strobe, pushed or dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= 16'd0;
      cap_cnt    <= 16'd0;
      settle_cnt <= 16'd0;
    end else if (accept_start) begin
      count_q    <= sample_count;
      cap_cnt    <= 16'd0;
      settle_cnt <= 16'd0;
    end else begin
      if ((state == SETTLE) && ds_valid) begin
        settle_cnt <= settle_cnt + 16'd1;
      end
      if (push_req) begin
        cap_cnt <= cap_cnt + 16'd1;
      end
    end
  end

  // Sticky overflow flag, cleared only by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (accept_start) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Buffer storage. It has no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ds_data;
    end
  end

  // Buffer pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
